// File: rtl/vram_scanout.sv
// VGA scanout of a 1bpp line-per-word VRAM. Each line is fetched into a buffer during blanking.
// Define SCANOUT_BORDER_EN to force an FG_COLOR frame around the active area.
module vram_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          PIX_DIV  = 4,
  parameter logic [7:0]  FG_COLOR = 8'hFF,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [H_ACTIVE-1:0] vram_rd_data_i,
  output logic [8:0]          vram_addr_o,
  output logic                vram_turn_o,
  output logic                pix_en_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic [7:0]          rgb_o,
  output logic                frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [VW-1:0]       vcnt_q, vcnt_d;
  logic [8:0]          tgt_q, tgt_d;
  logic [8:0]          addr_q, addr_d;
  logic                turn_q, turn_d;
  logic [H_ACTIVE-1:0] lbuf_q, lbuf_d;
  logic [7:0]          rgb_q, rgb_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                fs_q, fs_d;

  logic                pix_en;
  logic                active;
  logic [XW-1:0]       px;
  logic [VW-1:0]       v_next;
  logic                trigger;
  logic [7:0]          pix_rgb;

  assign pix_en  = (div_q == DIV_LAST);
  assign active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign px      = hcnt_q[XW-1:0];
  assign v_next  = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
  assign trigger = pix_en && (hcnt_q == H_ACT) && (v_next < V_ACT);

`ifdef SCANOUT_BORDER_EN
  logic on_border;
  assign on_border = (hcnt_q == '0) || (hcnt_q == HW'(H_ACTIVE - 1)) ||
                     (vcnt_q == '0) || (vcnt_q == VW'(V_ACTIVE - 1));
`endif

  always_comb begin
    div_d  = pix_en ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = v_next;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Sync and colour share one register stage so they stay aligned.
  always_comb begin
    pix_rgb = 8'h00;
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (active) begin
      pix_rgb = lbuf_q[px] ? FG_COLOR : BG_COLOR;
`ifdef SCANOUT_BORDER_EN
      if (on_border) pix_rgb = FG_COLOR;
`endif
    end
    if (pix_en) begin
      rgb_d = pix_rgb;
      hs_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    end
    fs_d = pix_en && (hcnt_q == '0) && (vcnt_q == '0);
  end

  // GRANT is a guard cycle so a writer mid-access finishes before the address moves.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    turn_d  = turn_q;
    lbuf_d  = lbuf_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_GRANT;
          tgt_d   = 9'(v_next);
          turn_d  = 1'b0;
        end
      end
      S_GRANT: begin
        state_d = S_ADDR;
        addr_d  = tgt_q;
      end
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_IDLE;
        lbuf_d  = vram_rd_data_i;
        turn_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      tgt_q   <= '0;
      addr_q  <= '0;
      turn_q  <= 1'b1;
      lbuf_q  <= '0;
      rgb_q   <= 8'h00;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      turn_q  <= turn_d;
      lbuf_q  <= lbuf_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign vram_addr_o   = addr_q;
  assign vram_turn_o   = turn_q;
  assign pix_en_o      = pix_en;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: full-size timing spot checks plus a small-geometry
// instance scored pixel by pixel against a frame-arithmetic reference model.
`timescale 1ns/1ps
module tb_vram_scanout;

  localparam int BHA = 16, BHFP = 2, BHS = 3, BHBP = 3;
  localparam int BVA = 6,  BVFP = 2, BVS = 1, BVBP = 2;
  localparam int BPD = 2;
  localparam int BHT = BHA + BHFP + BHS + BHBP;
  localparam int BVT = BVA + BVFP + BVS + BVBP;
  localparam int BF  = BHT * BVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- full-size instance A ----------------
  logic         rst_a = 1'b0;
  logic [639:0] rd_a  = '0;
  logic [8:0]   addr_a;
  logic         turn_a, pe_a, hs_a, vs_a, fs_a;
  logic [7:0]   rgb_a;
  int           ca = 0;

  vram_scanout dut_a (
    .clk_i(clk), .rst_ni(rst_a), .vram_rd_data_i(rd_a),
    .vram_addr_o(addr_a), .vram_turn_o(turn_a), .pix_en_o(pe_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .rgb_o(rgb_a),
    .frame_start_o(fs_a)
  );

  always @(posedge clk) if (!turn_a) rd_a <= (addr_a == 9'd5) ? 640'h1 : '0;
  always @(posedge clk) if (!rst_a) ca <= 0; else ca <= ca + 1;

  function automatic logic [7:0] exp_a(int h, int v);
    logic [7:0] r;
    r = (v == 5 && h == 0) ? 8'hFF : 8'h00;
`ifdef SCANOUT_BORDER_EN
    if (h == 0 || h == 639 || v == 0 || v == 479) r = 8'hFF;
`endif
    return r;
  endfunction

  task automatic wait_ca(input int n);
    while (ca < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_a();
    int t0, bad, p;
    repeat (10) @(negedge clk);
    chk("a_rst_turn", turn_a, 1);
    chk("a_rst_addr", addr_a, 0);
    chk("a_rst_rgb", rgb_a, 0);
    chk("a_rst_hsync", hs_a, 1);
    chk("a_rst_vsync", vs_a, 1);
    chk("a_rst_pix_en", pe_a, 0);
    chk("a_rst_frame_start", fs_a, 0);
    #2 rst_a = 1'b1;
    while (!fs_a && ca < 40) begin @(posedge clk); #1; end
    chk("a_first_frame_start_clk", ca, 4);
    while (hs_a && ca < 6000) begin @(posedge clk); #1; end
    chk("a_hsync_fall_clk", ca, 2628);
    t0 = ca;
    while (!hs_a && ca < t0 + 4000) begin @(posedge clk); #1; end
    chk("a_hsync_low_clks", ca - t0, 384);
    while (hs_a && ca < t0 + 8000) begin @(posedge clk); #1; end
    chk("a_hsync_period_clks", ca - t0, 3200);
    chk("a_vsync_idle", vs_a, 1);
    bad = 0;
    for (int y = 4; y <= 5; y++) begin
      for (int x = 0; x < 640; x++) begin
        p = y * 800 + x;
        wait_ca(4 * p + 4);
        if (y == 5 && x == 0) chk("a_line5_px0", rgb_a, exp_a(x, y));
        else if (y == 5 && x == 1) chk("a_line5_px1", rgb_a, exp_a(x, y));
        else if (rgb_a !== exp_a(x, y)) bad++;
      end
    end
    chk("a_lines4_5_bad_pixels", bad, 0);
    wait_ca(31363);
    chk("a_fetch9_turn_before", turn_a, 1);
    chk("a_fetch9_addr_before", addr_a, 9);
    wait_ca(31364);
    chk("a_fetch9_turn_fall", turn_a, 0);
    chk("a_fetch9_addr_guard", addr_a, 9);
    wait_ca(31365);
    chk("a_fetch9_turn_c2", turn_a, 0);
    chk("a_fetch9_addr_c2", addr_a, 10);
    wait_ca(31366);
    chk("a_fetch9_turn_c3", turn_a, 0);
    chk("a_fetch9_addr_c3", addr_a, 10);
    wait_ca(31367);
    chk("a_fetch9_turn_c4", turn_a, 0);
    wait_ca(31368);
    chk("a_fetch9_turn_back", turn_a, 1);
    chk("a_fetch9_addr_hold", addr_a, 10);
  endtask

  // ---------------- small instance B (scoreboarded) ----------------
  logic        rst_b = 1'b0;
  logic [15:0] rd_b  = '0;
  logic [8:0]  addr_b;
  logic        turn_b, pe_b, hs_b, vs_b, fs_b;
  logic [7:0]  rgb_b;
  logic [15:0] mem_b [BVA];

  vram_scanout #(
    .H_ACTIVE(BHA), .H_FP(BHFP), .H_SYNC(BHS), .H_BP(BHBP),
    .V_ACTIVE(BVA), .V_FP(BVFP), .V_SYNC(BVS), .V_BP(BVBP),
    .PIX_DIV(BPD), .FG_COLOR(8'hFF), .BG_COLOR(8'h00)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .vram_rd_data_i(rd_b),
    .vram_addr_o(addr_b), .vram_turn_o(turn_b), .pix_en_o(pe_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .rgb_o(rgb_b),
    .frame_start_o(fs_b)
  );

  always @(posedge clk)
    if (!turn_b) rd_b <= (addr_b < BVA) ? mem_b[addr_b[2:0]] : 16'hDEAD;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } pix_t;

  pix_t q_b[$];

  // Output seen at pixel tick t describes screen position t-1.
  function automatic pix_t exp_b(int t);
    pix_t r;
    int p, fr, h, v;
    logic b;
    r = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
    if (t > 0) begin
      p  = (t - 1) % BF;
      fr = (t - 1) / BF;
      h  = p % BHT;
      v  = p / BHT;
      r.hs = !(h >= BHA + BHFP && h < BHA + BHFP + BHS);
      r.vs = !(v >= BVA + BVFP && v < BVA + BVFP + BVS);
      if (h < BHA && v < BVA) begin
        b = (fr == 0 && v == 0) ? 1'b0 : mem_b[v][h];
        r.rgb = b ? 8'hFF : 8'h00;
`ifdef SCANOUT_BORDER_EN
        if (h == 0 || h == BHA - 1 || v == 0 || v == BVA - 1) r.rgb = 8'hFF;
`endif
      end
    end
    return r;
  endfunction

  int k_b = 0, since_b = 0, tgt_b = 0;
  int t_b, pos_b, h_b, v_b, nxt_b;
  bit act_b = 0, trig_b = 0, pos0_b = 0;
  bit exp_turn_b = 1, exp_fs_b = 0, exp_pe_b = 0;

  // Reference model: clock index since reset -> tick index -> frame position.
  always @(posedge clk) begin
    if (!rst_b) begin
      k_b = 0; since_b = 0; trig_b = 0; pos0_b = 0;
      act_b = 0; exp_turn_b = 1; exp_fs_b = 0; exp_pe_b = 0;
      q_b.delete();
    end else begin
      act_b = 1;
      k_b++;
      exp_fs_b = pos0_b;
      if (trig_b) since_b = 1;
      else if (since_b != 0) since_b = (since_b == 4) ? 0 : since_b + 1;
      exp_turn_b = (since_b == 0);
      trig_b = 0;
      pos0_b = 0;
      exp_pe_b = (k_b % BPD == BPD - 1);
      if (exp_pe_b) begin
        t_b   = (k_b - (BPD - 1)) / BPD;
        pos_b = t_b % BF;
        h_b   = pos_b % BHT;
        v_b   = pos_b / BHT;
        nxt_b = (v_b == BVT - 1) ? 0 : v_b + 1;
        pos0_b = (pos_b == 0);
        if (h_b == BHA && nxt_b < BVA) begin
          trig_b = 1;
          tgt_b  = nxt_b;
        end
        if (h_b == 0 && v_b == BVA + 1)
          for (int i = 0; i < BVA; i++) mem_b[i] = 16'($urandom);
        q_b.push_back(exp_b(t_b));
      end
    end
  end

  pix_t e_b;
  always @(negedge clk) begin
    if (act_b && rst_b) begin
      chk("b_pix_en", pe_b, exp_pe_b);
      if (pe_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_pixel", 1, 0);
        end else begin
          e_b = q_b.pop_front();
          chk("b_rgb", rgb_b, e_b.rgb);
          chk("b_hsync", hs_b, e_b.hs);
          chk("b_vsync", vs_b, e_b.vs);
        end
      end
      chk("b_turn", turn_b, exp_turn_b);
      if (since_b >= 2) chk("b_addr", addr_b, tgt_b);
      if (exp_fs_b || fs_b) chk("b_frame_start", fs_b, exp_fs_b);
    end
  end

  task automatic run_b();
    int n;
    for (int i = 0; i < BVA; i++) mem_b[i] = 16'($urandom);
    repeat (6) @(negedge clk);
    chk("b_rst_turn", turn_b, 1);
    chk("b_rst_rgb", rgb_b, 0);
    chk("b_rst_sync", {hs_b, vs_b}, 2'b11);
    #2 rst_b = 1'b1;
    repeat (3 * BF * BPD + 7) @(negedge clk);
    n = 0;
    while (since_b != 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b_fetch_wait_reached", since_b, 3);
    #2 rst_b = 1'b0;
    @(negedge clk);
    chk("b_midrst_turn", turn_b, 1);
    chk("b_midrst_rgb", rgb_b, 0);
    chk("b_midrst_sync", {hs_b, vs_b}, 2'b11);
    chk("b_midrst_pix_en", pe_b, 0);
    chk("b_midrst_frame_start", fs_b, 0);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    repeat (2 * BF * BPD + 9) @(negedge clk);
    #1;
    chk("b_pending_expect", q_b.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
